idx_onehot_tracker: RTL and testbench

Inverse of the slot-index priority encoder. Accepts a stream of encoded slot indices in the same OUT_WIDTH format (MSB set = "not found"). Decodes each index to one-hot and applies it as SET or CLR to a registered slot-occupancy vector. Also emits a registered one-hot beat per command and keeps an occupancy count plus a sticky protocol-error flag. Sits in the prefetcher beside the encoder: the encoder picks a free or valid slot, and this block commits the allocation or release.

---
 rtl/idx_onehot_tracker_pkg.sv | 25 ++
 rtl/idx_onehot_tracker_idx_to_onehot.sv | 44 ++++
 rtl/idx_onehot_tracker.sv | 111 +++++++++++
 tb/tb_idx_onehot_tracker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/idx_onehot_tracker_pkg.sv
// ---------------------------------------------------------------------------
// idx_onehot_tracker_pkg
// Shared prefetcher definitions for the slot-index encoder/tracker pair.
//   - OP_SET / OP_CLR : command opcodes carried on in_op / out_op.
//   - null_bit_pos()  : bit position of the "not found" flag in an encoded
//                       index of a given width (its MSB).
//   - idx_is_null()   : null test on the MSB flag alone; range checks against
//                       a narrower slot count are done by the decoder.
// ---------------------------------------------------------------------------
package idx_onehot_tracker_pkg;

    localparam logic OP_SET = 1'b0;
    localparam logic OP_CLR = 1'b1;

    localparam int DEF_OUT_WIDTH = 4;

    function automatic int null_bit_pos(input int out_width);
        return out_width - 1;
    endfunction

    function automatic logic idx_is_null(input logic msb_flag);
        return msb_flag;
    endfunction

endpackage

// File: rtl/idx_onehot_tracker_idx_to_onehot.sv
// ---------------------------------------------------------------------------
// idx_to_onehot
// Combinational decode of an encoded slot index into a one-hot slot vector.
// Exact dual of the slot-index priority encoder: an index with its MSB set,
// or whose low bits address a slot at or beyond IN_WIDTH, is null and
// decodes to all-zero.
// Ports:
//   idx     [OUT_WIDTH-1:0] : encoded slot index (MSB = not found)
//   onehot  [IN_WIDTH-1:0]  : decoded one-hot, zero when null
//   is_null                 : index is null
// ---------------------------------------------------------------------------
module idx_to_onehot
    import idx_onehot_tracker_pkg::*;
#(
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int IN_WIDTH  = 1 << (OUT_WIDTH - 1)
) (
    input  logic [OUT_WIDTH-1:0] idx,
    output logic [IN_WIDTH-1:0]  onehot,
    output logic                 is_null
);

    localparam int LW = OUT_WIDTH - 1;
    // Slot count held in OUT_WIDTH bits so the range compare is width-exact.
    localparam logic [OUT_WIDTH-1:0] SLOTS = OUT_WIDTH'(IN_WIDTH);

    logic [LW-1:0] low;

    assign low = idx[LW-1:0];

    always_comb begin
        onehot  = '0;
        is_null = idx_is_null(idx[null_bit_pos(OUT_WIDTH)]) ||
                  ({1'b0, low} >= SLOTS);
        if (!is_null) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (low == LW'(i)) begin
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/idx_onehot_tracker.sv
// ---------------------------------------------------------------------------
// idx_onehot_tracker
// Commits slot allocations/releases chosen by the slot-index encoder. Each
// accepted command decodes its index to one-hot, SETs or CLRs that bit in a
// registered occupancy vector, and is forwarded as a one-hot beat through a
// single-entry output register.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready : command handshake; in_ready = !out_valid || out_ready
//   in_idx            : encoded slot index (MSB = null)
//   in_op             : OP_SET / OP_CLR
//   clr_all           : synchronous clear of slot_vec, slot_cnt and err
//   out_valid/out_ready, out_onehot, out_op : one-hot beat stream
//   slot_vec          : occupancy vector
//   slot_cnt          : popcount of slot_vec
//   err               : sticky flag for SET of a set slot / CLR of a clear slot
// ---------------------------------------------------------------------------
module idx_onehot_tracker
    import idx_onehot_tracker_pkg::*;
#(
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int IN_WIDTH  = 1 << (OUT_WIDTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OUT_WIDTH-1:0] in_idx,
    input  logic                 in_op,
    input  logic                 clr_all,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IN_WIDTH-1:0]  out_onehot,
    output logic                 out_op,
    output logic [IN_WIDTH-1:0]  slot_vec,
    output logic [OUT_WIDTH-1:0] slot_cnt,
    output logic                 err
);

    logic [IN_WIDTH-1:0] dec_p0;
    logic                null_p0;
    logic                accept_p0;
    logic                hit_p0;
    logic                vld_p1;
    logic [IN_WIDTH-1:0] onehot_p1;
    logic                op_p1;

    idx_to_onehot #(
        .OUT_WIDTH (OUT_WIDTH),
        .IN_WIDTH  (IN_WIDTH)
    ) u_dec (
        .idx     (in_idx),
        .onehot  (dec_p0),
        .is_null (null_p0)
    );

    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;
    // Addressed slot is currently occupied (always 0 for a null index).
    assign hit_p0    = |(slot_vec & dec_p0);

    // ---- stage p0 -> p1 : output beat register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            onehot_p1 <= '0;
            op_p1     <= 1'b0;
        end else if (in_ready) begin
            // Register is empty or draining this cycle: load or go empty.
            vld_p1 <= in_valid;
            if (in_valid) begin
                onehot_p1 <= dec_p0;
                op_p1     <= in_op;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign out_onehot = onehot_p1;
    assign out_op     = op_p1;

    // ---- stage p0 -> p1 : occupancy commit on acceptance ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vec <= '0;
            slot_cnt <= '0;
            err      <= 1'b0;
        end else if (clr_all) begin
            slot_vec <= '0;
            slot_cnt <= '0;
            err      <= 1'b0;
        end else if (accept_p0 && !null_p0) begin
            if (in_op == OP_SET) begin
                if (hit_p0) begin
                    err <= 1'b1;
                end else begin
                    slot_vec <= slot_vec | dec_p0;
                    slot_cnt <= slot_cnt + OUT_WIDTH'(1);
                end
            end else begin
                if (!hit_p0) begin
                    err <= 1'b1;
                end else begin
                    slot_vec <= slot_vec & ~dec_p0;
                    slot_cnt <= slot_cnt - OUT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_idx_onehot_tracker.sv
module tb_idx_onehot_tracker;

    localparam int OW = 4;
    localparam int IW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_idx;
    logic          in_op;
    logic          clr_all;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_onehot;
    logic          out_op;
    logic [IW-1:0] slot_vec;
    logic [OW-1:0] slot_cnt;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model: a set of occupied slots, a sticky flag and the beat
    // currently held at the output.
    bit            m_occ[IW];
    bit            m_err;
    bit            m_vld;
    logic [IW-1:0] m_onehot;
    logic          m_op;

    idx_onehot_tracker #(.OUT_WIDTH(OW), .IN_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_op      (in_op),
        .clr_all    (clr_all),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_op     (out_op),
        .slot_vec   (slot_vec),
        .slot_cnt   (slot_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] m_vec();
        logic [IW-1:0] v = '0;
        for (int i = 0; i < IW; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic logic [OW-1:0] m_cnt();
        int n = 0;
        for (int i = 0; i < IW; i++) n += int'(m_occ[i]);
        return OW'(n);
    endfunction

    function automatic bit m_ready();
        return !m_vld || out_ready;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < IW; i++) m_occ[i] = 0;
        m_err = 0; m_vld = 0; m_onehot = '0; m_op = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs presented.
    task automatic step();
        bit acc, nul;
        int slot;
        acc  = in_valid && m_ready();
        slot = int'(in_idx[OW-2:0]);
        nul  = in_idx[OW-1] || (slot >= IW);
        if (acc) begin
            m_vld = 1; m_op = in_op;
            m_onehot = nul ? '0 : (IW'(1) << slot);
        end else if (out_ready) begin
            m_vld = 0;
        end
        if (clr_all) begin
            for (int i = 0; i < IW; i++) m_occ[i] = 0;
            m_err = 0;
        end else if (acc && !nul) begin
            if (in_op == 1'b0) begin
                if (m_occ[slot]) m_err = 1; else m_occ[slot] = 1;
            end else begin
                if (!m_occ[slot]) m_err = 1; else m_occ[slot] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [OW-1:0] idx, input logic op, input bit ca, input bit ordy);
        in_valid = v; in_idx = idx; in_op = op; clr_all = ca; out_ready = ordy;
    endtask

    task automatic settle_clear();
        drive(0, '0, 0, 1, 1); step();
        drive(0, '0, 0, 0, 1); step();
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 1);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_onehot !== 8'h00 || out_op !== 1'b0) begin errors++; $display("FAIL reset_beat: got %h/%b expected 00/0", out_onehot, out_op); end
        checks++; if (slot_vec !== 8'h00 || slot_cnt !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_state: got vec %h cnt %0d err %b expected 00 0 0", slot_vec, slot_cnt, err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_set_basic();
        drive(1, 4'd3, 0, 0, 1); step();
        checks++; if (out_valid !== 1'b1 || out_onehot !== 8'h08) begin errors++; $display("FAIL set3_beat: got v%b %h expected v1 08", out_valid, out_onehot); end
        drive(1, 4'd0, 0, 0, 1); step();
        checks++; if (out_valid !== 1'b1 || out_onehot !== 8'h01) begin errors++; $display("FAIL set0_beat: got v%b %h expected v1 01", out_valid, out_onehot); end
        checks++; if (slot_vec !== 8'h09 || slot_cnt !== 4'd2 || err !== 1'b0) begin errors++; $display("FAIL set_basic_state: got vec %h cnt %0d err %b expected 09 2 0", slot_vec, slot_cnt, err); end
        drive(0, '0, 0, 0, 1); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL set_basic_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_double_set_err();
        settle_clear();
        drive(1, 4'd3, 0, 0, 1); step();
        drive(1, 4'd3, 0, 0, 1); step();
        checks++; if (out_onehot !== 8'h08) begin errors++; $display("FAIL dset_beat: got %h expected 08", out_onehot); end
        checks++; if (slot_vec !== 8'h08 || slot_cnt !== 4'd1 || err !== 1'b1) begin errors++; $display("FAIL dset_state: got vec %h cnt %0d err %b expected 08 1 1", slot_vec, slot_cnt, err); end
        drive(0, '0, 0, 0, 1); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        drive(0, '0, 0, 1, 1); step();
        checks++; if (slot_vec !== 8'h00 || slot_cnt !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL clr_all_state: got vec %h cnt %0d err %b expected 00 0 0", slot_vec, slot_cnt, err); end
        clr_all = 0;
    endtask

    task automatic test_clr_empty_err();
        settle_clear();
        drive(1, 4'd2, 1, 0, 1); step();
        checks++; if (out_onehot !== 8'h04 || out_op !== 1'b1 || err !== 1'b1 || slot_cnt !== 4'd0) begin errors++; $display("FAIL clr_empty: got %h op %b err %b cnt %0d expected 04 1 1 0", out_onehot, out_op, err, slot_cnt); end
    endtask

    task automatic test_null();
        settle_clear();
        drive(1, 4'd6, 0, 0, 1); step();
        drive(1, 4'b1000, 1, 0, 1); step();
        checks++; if (out_valid !== 1'b1 || out_onehot !== 8'h00 || out_op !== 1'b1) begin errors++; $display("FAIL null_beat: got v%b %h op %b expected v1 00 1", out_valid, out_onehot, out_op); end
        checks++; if (slot_vec !== 8'h40 || slot_cnt !== 4'd1 || err !== 1'b0) begin errors++; $display("FAIL null_state: got vec %h cnt %0d err %b expected 40 1 0", slot_vec, slot_cnt, err); end
        drive(1, 4'b1110, 0, 0, 1); step();
        checks++; if (out_onehot !== 8'h00 || slot_vec !== 8'h40 || err !== 1'b0) begin errors++; $display("FAIL null_set: got %h vec %h err %b expected 00 40 0", out_onehot, slot_vec, err); end
    endtask

    task automatic test_stall();
        settle_clear();
        drive(1, 4'd5, 0, 0, 0); step();
        drive(1, 4'd6, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0 (cycle %0d)", in_ready, k); end
            step();
            checks++; if (out_valid !== 1'b1 || out_onehot !== 8'h20 || slot_vec !== 8'h20) begin errors++; $display("FAIL stall_hold: got v%b %h vec %h expected v1 20 20 (cycle %0d)", out_valid, out_onehot, slot_vec, k); end
        end
        out_ready = 1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        step();
        checks++; if (out_onehot !== 8'h40 || slot_vec !== 8'h60 || slot_cnt !== 4'd2) begin errors++; $display("FAIL release_accept: got %h vec %h cnt %0d expected 40 60 2", out_onehot, slot_vec, slot_cnt); end
    endtask

    task automatic test_back_to_back();
        settle_clear();
        for (int i = 0; i < IW; i++) begin
            drive(1, OW'(i), 0, 0, 1); step();
            checks++; if (out_onehot !== (IW'(1) << i) || slot_cnt !== OW'(i + 1)) begin errors++; $display("FAIL b2b_set%0d: got %h cnt %0d expected %h %0d", i, out_onehot, slot_cnt, IW'(1) << i, i + 1); end
        end
        checks++; if (slot_vec !== 8'hFF || slot_cnt !== 4'b1000) begin errors++; $display("FAIL b2b_full: got vec %h cnt %0d expected ff 8", slot_vec, slot_cnt); end
        drive(1, 4'd7, 1, 1, 1); step();
        checks++; if (out_valid !== 1'b1 || out_onehot !== 8'h80 || out_op !== 1'b1) begin errors++; $display("FAIL clr_with_clrall_beat: got v%b %h op %b expected v1 80 1", out_valid, out_onehot, out_op); end
        checks++; if (slot_vec !== 8'h00 || slot_cnt !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL clr_with_clrall_state: got vec %h cnt %0d err %b expected 00 0 0", slot_vec, slot_cnt, err); end
        drive(0, '0, 0, 0, 1);
    endtask

    task automatic test_random();
        settle_clear();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, OW'($urandom_range(0, 15) > 12 ? $urandom_range(8, 15) : $urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
            #1;
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", n, in_ready, m_ready()); end
            step();
            checks++; if (out_valid !== m_vld || (m_vld && (out_onehot !== m_onehot || out_op !== m_op))) begin errors++; $display("FAIL rnd_beat[%0d]: got v%b %h op %b expected v%b %h op %b", n, out_valid, out_onehot, out_op, m_vld, m_onehot, m_op); end
            checks++; if (slot_vec !== m_vec() || slot_cnt !== m_cnt() || err !== m_err) begin errors++; $display("FAIL rnd_state[%0d]: got vec %h cnt %0d err %b expected %h %0d %b", n, slot_vec, slot_cnt, err, m_vec(), m_cnt(), m_err); end
        end
    endtask

    task automatic test_async_reset();
        settle_clear();
        drive(1, 4'd4, 0, 0, 1); step();
        drive(1, 4'd4, 0, 0, 0); step();
        drive(0, '0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || slot_vec !== 8'h00 || slot_cnt !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL async_reset: got v%b vec %h cnt %0d err %b expected 0 00 0 0", out_valid, slot_vec, slot_cnt, err); end
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin errors++; $display("FAIL async_reset_drop: got v%b %h expected v0 00", out_valid, out_onehot); end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, '0, 0, 0, 1);
        test_reset();
        test_set_basic();
        test_double_set_err();
        test_clr_empty_err();
        test_null();
        test_stall();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
